// File: rtl/avmm_wr_burst_splitter_if.sv
// ----------------------------------------------------------------------------
// avmm_wr_burst_splitter_if
// One AVMM write channel: address, burstcount, writedata, write, waitrequest.
// The splitter uses one instance on its upstream side (slave modport) and one
// on its downstream side (master modport).
//
// Handshake: a beat transfers on a clock edge where write=1 and
// waitrequest=0. While waitrequest=1 the master holds address, burstcount,
// writedata and write stable.
//
// Signals:
//   address     master->slave  ADDR_WIDTH   byte address of the burst
//   burstcount  master->slave  BURST_WIDTH  burst length in lines
//   writedata   master->slave  DATA_WIDTH   one cache line per beat
//   write       master->slave  1            beat valid
//   waitrequest slave->master  1            backpressure
// ----------------------------------------------------------------------------
interface avmm_wr_burst_splitter_if #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]  address;
    logic [BURST_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]  writedata;
    logic                   write;
    logic                   waitrequest;

    modport master (
        output address,
        output burstcount,
        output writedata,
        output write,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  burstcount,
        input  writedata,
        input  write,
        output waitrequest
    );
endinterface

// File: rtl/avmm_wr_burst_splitter.sv
// ----------------------------------------------------------------------------
// avmm_wr_burst_splitter
// Re-issues arbitrary-length AVMM write bursts of cache lines as sub-bursts of
// 1, 2 or 4 lines, each naturally aligned to its length. Data is passed
// through with zero latency; only address and burstcount are rewritten.
//
// Ports:
//   clk             in   clock
//   reset_n         in   asynchronous active-low reset
//   in_bus          slave modport, upstream burst (burstcount up to 64)
//   out_bus         master modport, downstream sub-bursts (burstcount 1/2/4)
//   busy            out  high while inside a multi-beat input burst
//   err_zero_burst  out  sticky, an input burst with burstcount 0 was accepted
//   sub_burst_count out  number of sub-bursts issued (wraps)
//   o_dbg_state     out  FSM state (0=IDLE, 1=BURST)
// ----------------------------------------------------------------------------
module avmm_wr_burst_splitter #(
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 512,
    parameter int IN_BURST_WIDTH = 7,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    avmm_wr_burst_splitter_if.slave  in_bus,
    avmm_wr_burst_splitter_if.master out_bus,
    output logic                   busy,
    output logic                   err_zero_burst,
    output logic [COUNT_WIDTH-1:0] sub_burst_count,
    output logic                   o_dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IN_BURST_WIDTH-1:0] r_total_left;
    logic [1:0]                r_beat_idx;
    logic [2:0]                r_sub_len;
    logic [ADDR_WIDTH-1:0]     r_cur_addr;
    logic                      r_err_zero;
    logic [COUNT_WIDTH-1:0]    r_sub_cnt;

    logic                      w_accept;
    logic                      w_zero_bc;
    logic [ADDR_WIDTH-1:0]     w_eff_addr;
    logic [IN_BURST_WIDTH-1:0] w_eff_total;
    logic [2:0]                w_new_len;
    logic                      w_sub_first;
    logic [2:0]                w_len;
    logic                      w_sub_end;
    logic [ADDR_WIDTH-1:0]     w_next_addr;

    // Pure pass-through of data, valid and backpressure.
    assign out_bus.writedata = in_bus.writedata;
    assign out_bus.write     = in_bus.write;
    assign in_bus.waitrequest = out_bus.waitrequest;

    always_comb begin
        w_accept    = in_bus.write && !out_bus.waitrequest;
        w_zero_bc   = (in_bus.burstcount == '0);
        // In IDLE the current beat opens a new input burst, so address and
        // length come straight from the bus; afterwards from the registers.
        if (r_state == IDLE) begin
            w_eff_addr  = {in_bus.address[ADDR_WIDTH-1:6], 6'b0};
            w_eff_total = w_zero_bc ? IN_BURST_WIDTH'(1) : in_bus.burstcount;
        end else begin
            w_eff_addr  = r_cur_addr;
            w_eff_total = r_total_left;
        end
        // Largest aligned length that fits in the remaining lines.
        if ((w_eff_total >= IN_BURST_WIDTH'(4)) && (w_eff_addr[7:6] == 2'b00)) begin
            w_new_len = 3'd4;
        end else if ((w_eff_total >= IN_BURST_WIDTH'(2)) && !w_eff_addr[6]) begin
            w_new_len = 3'd2;
        end else begin
            w_new_len = 3'd1;
        end
        w_sub_first = (r_beat_idx == 2'd0);
        w_len       = w_sub_first ? w_new_len : r_sub_len;
        w_sub_end   = (({1'b0, r_beat_idx} + 3'd1) == w_len);
        w_next_addr = w_eff_addr + ADDR_WIDTH'({w_len, 6'b0});
    end

    // cur_addr only moves at sub-burst ends, so within a sub-burst the
    // effective address is still its start address: later beats repeat it.
    assign out_bus.address    = w_eff_addr;
    assign out_bus.burstcount = w_len;

    // Sub-burst length never exceeds the remaining lines, so the last input
    // beat is always also the last beat of a sub-burst.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_eff_total > IN_BURST_WIDTH'(1))) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (w_accept && (r_total_left == IN_BURST_WIDTH'(1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total_left <= '0;
            r_beat_idx   <= 2'd0;
            r_sub_len    <= 3'd0;
            r_cur_addr   <= '0;
            r_err_zero   <= 1'b0;
            r_sub_cnt    <= '0;
        end else if (w_accept) begin
            r_total_left <= w_eff_total - IN_BURST_WIDTH'(1);
            if ((r_state == IDLE) && w_zero_bc) begin
                r_err_zero <= 1'b1;
            end
            if (w_sub_first) begin
                r_sub_len <= w_new_len;
                r_sub_cnt <= r_sub_cnt + COUNT_WIDTH'(1);
            end
            if (w_sub_end) begin
                r_beat_idx <= 2'd0;
                r_cur_addr <= w_next_addr;
            end else begin
                r_beat_idx <= r_beat_idx + 2'd1;
                r_cur_addr <= w_eff_addr;
            end
        end
    end

    assign busy            = (r_state == BURST);
    assign err_zero_burst  = r_err_zero;
    assign sub_burst_count = r_sub_cnt;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_avmm_wr_burst_splitter.sv
module tb_avmm_wr_burst_splitter;

    logic        clk;
    logic        reset_n;
    logic        busy;
    logic        err_zero_burst;
    logic [31:0] sub_burst_count;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    avmm_wr_burst_splitter_if #(.ADDR_WIDTH(48), .DATA_WIDTH(512), .BURST_WIDTH(7)) in_if ();
    avmm_wr_burst_splitter_if #(.ADDR_WIDTH(48), .DATA_WIDTH(512), .BURST_WIDTH(3)) out_if ();

    avmm_wr_burst_splitter #(
        .ADDR_WIDTH(48), .DATA_WIDTH(512), .IN_BURST_WIDTH(7), .COUNT_WIDTH(32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_bus         (in_if),
        .out_bus        (out_if),
        .busy           (busy),
        .err_zero_burst (err_zero_burst),
        .sub_burst_count(sub_burst_count),
        .o_dbg_state    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat (called just after a rising edge), optionally with
    // downstream backpressure for 'stalls' cycles, checks the outputs before
    // the accepting edge, and returns just after that edge.
    task automatic beat(input string tag, input logic [47:0] a, input logic [6:0] bc,
                        input logic [31:0] d, input logic [47:0] ea, input logic [2:0] eb,
                        input logic ebusy, input int stalls);
        in_if.address    = a;
        in_if.burstcount = bc;
        in_if.writedata  = {16{d}};
        in_if.write      = 1'b1;
        for (int i = 0; i < stalls; i++) begin
            out_if.waitrequest = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_wr"}, in_if.waitrequest, 1);
            chk({tag, "_stall_addr"}, out_if.address, ea);
            chk({tag, "_stall_bc"}, out_if.burstcount, eb);
            @(posedge clk);
            #1;
        end
        out_if.waitrequest = 1'b0;
        @(negedge clk);
        chk({tag, "_wr"}, in_if.waitrequest, 0);
        chk({tag, "_write"}, out_if.write, 1);
        chk({tag, "_data"}, out_if.writedata, {16{d}});
        chk({tag, "_addr"}, out_if.address, ea);
        chk({tag, "_bc"}, out_if.burstcount, eb);
        chk({tag, "_busy"}, busy, ebusy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic ebusy);
        in_if.write = 1'b0;
        @(negedge clk);
        chk({tag, "_write"}, out_if.write, 0);
        chk({tag, "_busy"}, busy, ebusy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n            = 1'b0;
        in_if.address      = '0;
        in_if.burstcount   = '0;
        in_if.writedata    = '0;
        in_if.write        = 1'b0;
        out_if.waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err_zero_burst, 0);
        chk("rst_cnt", sub_burst_count, 0);
        chk("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        idle("rst_idle", 0);

        // Aligned 4-line burst: one sub-burst.
        beat("t1b0", 48'h1000, 7'd4, 32'hA0, 48'h1000, 3'd4, 0, 0);
        beat("t1b1", 48'h0, 7'd0, 32'hA1, 48'h1000, 3'd4, 1, 0);
        beat("t1b2", 48'h0, 7'd0, 32'hA2, 48'h1000, 3'd4, 1, 0);
        beat("t1b3", 48'h0, 7'd0, 32'hA3, 48'h1000, 3'd4, 1, 0);
        chk("t1_cnt", sub_burst_count, 1);

        // Misaligned 8-line burst, back-to-back with the previous one.
        beat("t2b0", 48'h1040, 7'd8, 32'hB0, 48'h1040, 3'd1, 0, 0);
        beat("t2b1", 48'h0, 7'd0, 32'hB1, 48'h1080, 3'd2, 1, 0);
        beat("t2b2", 48'h0, 7'd0, 32'hB2, 48'h1080, 3'd2, 1, 0);
        beat("t2b3", 48'h0, 7'd0, 32'hB3, 48'h1100, 3'd4, 1, 0);
        beat("t2b4", 48'h0, 7'd0, 32'hB4, 48'h1100, 3'd4, 1, 0);
        beat("t2b5", 48'h0, 7'd0, 32'hB5, 48'h1100, 3'd4, 1, 0);
        beat("t2b6", 48'h0, 7'd0, 32'hB6, 48'h1100, 3'd4, 1, 0);
        beat("t2b7", 48'h0, 7'd0, 32'hB7, 48'h1200, 3'd1, 1, 0);
        chk("t2_cnt", sub_burst_count, 5);
        idle("t2_idle", 0);

        // 8-line burst with a 3-cycle stall on the third beat.
        beat("t3b0", 48'h2000, 7'd8, 32'hC0, 48'h2000, 3'd4, 0, 0);
        beat("t3b1", 48'h0, 7'd0, 32'hC1, 48'h2000, 3'd4, 1, 0);
        beat("t3b2", 48'h0, 7'd0, 32'hC2, 48'h2000, 3'd4, 1, 3);
        beat("t3b3", 48'h0, 7'd0, 32'hC3, 48'h2000, 3'd4, 1, 0);
        chk("t3_mid_cnt", sub_burst_count, 6);
        beat("t3b4", 48'h0, 7'd0, 32'hC4, 48'h2100, 3'd4, 1, 0);
        beat("t3b5", 48'h0, 7'd0, 32'hC5, 48'h2100, 3'd4, 1, 0);
        beat("t3b6", 48'h0, 7'd0, 32'hC6, 48'h2100, 3'd4, 1, 0);
        beat("t3b7", 48'h0, 7'd0, 32'hC7, 48'h2100, 3'd4, 1, 0);
        chk("t3_cnt", sub_burst_count, 7);

        // Zero burstcount: single line, sticky error.
        chk("t4_err_pre", err_zero_burst, 0);
        beat("t4b0", 48'h3000, 7'd0, 32'hD0, 48'h3000, 3'd1, 0, 0);
        chk("t4_err", err_zero_burst, 1);
        chk("t4_cnt", sub_burst_count, 8);
        idle("t4_idle0", 0);
        idle("t4_idle1", 0);
        chk("t4_err_hold", err_zero_burst, 1);

        // Reset in the middle of an 8-line burst.
        beat("t5b0", 48'h4000, 7'd8, 32'hE0, 48'h4000, 3'd4, 0, 0);
        beat("t5b1", 48'h0, 7'd0, 32'hE1, 48'h4000, 3'd4, 1, 0);
        beat("t5b2", 48'h0, 7'd0, 32'hE2, 48'h4000, 3'd4, 1, 0);
        in_if.write = 1'b0;
        chk("t5_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_cnt", sub_burst_count, 0);
        chk("t5_err", err_zero_burst, 0);
        chk("t5_state", dbg_state, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        beat("t5n0", 48'h5000, 7'd2, 32'hF0, 48'h5000, 3'd2, 0, 0);
        beat("t5n1", 48'h0, 7'd0, 32'hF1, 48'h5000, 3'd2, 1, 0);
        chk("t5n_cnt", sub_burst_count, 1);

        // Address wrap at the top of the address space.
        beat("t6b0", 48'hFFFF_FFFF_FFC0, 7'd2, 32'h60, 48'hFFFF_FFFF_FFC0, 3'd1, 0, 0);
        beat("t6b1", 48'h0, 7'd0, 32'h61, 48'h0, 3'd1, 1, 0);
        chk("t6_cnt", sub_burst_count, 3);

        // Low address bits are ignored.
        beat("t7b0", 48'h6013, 7'd1, 32'h70, 48'h6000, 3'd1, 0, 0);
        idle("t7_idle", 0);
        chk("t7_cnt", sub_burst_count, 4);
        chk("t7_err", err_zero_burst, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avmm_wr_burst_splitter.md
Name: avmm_wr_burst_splitter

Overview:
- Sits between the DMA test system's requestor-write AVMM master and the host-write CCI-P bridge.
- Accepts arbitrary-length AVMM write bursts of cache lines and re-issues them as CCI-P-legal sub-bursts: length 1, 2 or 4 lines, naturally aligned to their length. Sub-bursts therefore never cross a 4 KB page.
- Data path is zero-latency pass-through. The block only tracks burst position and rewrites address/burstcount.

Parameters:
ADDR_WIDTH, 48, byte address width; addresses are 64-byte line aligned
DATA_WIDTH, 512, data width (one cache line per beat)
IN_BURST_WIDTH, 7, input burstcount width (max 64 lines)
COUNT_WIDTH, 32, width of sub-burst statistics counter

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
in_address  in  ADDR_WIDTH  byte address of first line; sampled on first beat only
in_burstcount  in  IN_BURST_WIDTH  burst length in lines; sampled on first beat only
in_writedata  in  DATA_WIDTH  write data
in_write  in  1  write beat valid
in_waitrequest  out  1  backpressure to upstream master
out_address  out  ADDR_WIDTH  sub-burst byte address, bits[5:0]=0
out_burstcount  out  3  sub-burst length: 1, 2 or 4
out_writedata  out  DATA_WIDTH  write data
out_write  out  1  write beat valid
out_waitrequest  in  1  backpressure from host-write bridge
busy  out  1  high while inside a multi-beat input burst
err_zero_burst  out  1  sticky flag: input burst with burstcount 0 seen
sub_burst_count  out  COUNT_WIDTH  number of sub-bursts issued, wraps

Behaviour:
- Reset is asynchronous active-low. It clears all registers: state=IDLE, busy=0, err_zero_burst=0, sub_burst_count=0, internal counters 0.
- Combinational outputs after reset:
  - in_waitrequest=out_waitrequest
  - out_write=in_write
  - out_writedata=in_writedata
- Beat accepted when in_write && !out_waitrequest. No buffering, zero-cycle latency. Beat order is preserved exactly.
- FSM states:
  - IDLE: the current beat is the first beat of an input burst. Effective address = {in_address[ADDR_WIDTH-1:6],6'b0}. Effective total = in_burstcount, with 0 treated as 1 and err_zero_burst set on acceptance.
  - BURST: effective address = cur_addr register; remaining lines = total_left register.
- Sub-burst length L, computed from line index A=addr>>6 and remaining R:
  - R>=4 and A[1:0]==0 -> 4
  - else R>=2 and A[0]==0 -> 2
  - else 1
- out_address/out_burstcount are driven from the effective address and L at the first beat of each sub-burst. They hold their sub-burst values on later beats, where they are don't-care to the downstream bridge.
- Registers: total_left (lines remaining incl. current), beat_idx (beat within sub-burst), sub_len, cur_addr.
- On each accepted beat:
  - total_left decrements.
  - If beat_idx==0: latch sub_len=L and increment sub_burst_count.
  - If beat_idx+1==sub_len (or L==1 on a first beat): the sub-burst ends, beat_idx=0, cur_addr += sub_len*64 (modulo 2^ADDR_WIDTH, wrap allowed). Otherwise beat_idx increments.
- IDLE->BURST on an accepted first beat with effective total>1; busy=1 from the next cycle.
- BURST->IDLE on acceptance of the beat that brings total_left to 0; busy=0 from the next cycle.
- Total of 1 stays in IDLE. Back-to-back bursts need no idle cycle.
- Stalls: in_write low or waitrequest high leaves all state unchanged.
- Reset mid-burst aborts the burst immediately. Upstream is responsible for not resuming the partial burst.

Test Plan:
- in_address=0x1000, burstcount=4, no backpressure -> one sub-burst (0x1000,4), 4 beats in order; sub_burst_count=1; busy high cycles 2-4.
- in_address=0x1040, burstcount=8 -> sub-bursts (0x1040,1),(0x1080,2),(0x1100,4),(0x1200,1); 8 data beats unchanged; sub_burst_count=4.
- 8-beat burst at 0x2000 with out_waitrequest high for 3 cycles during beat 3 -> in_waitrequest mirrors it; no beat lost or duplicated; output (0x2000,4),(0x2100,4).
- burstcount=0 at 0x3000 -> single beat (0x3000,1); err_zero_burst=1 and held until reset_n low.
- reset_n pulsed low after 3 beats of an 8-beat burst at 0x4000 -> busy=0, counters=0 asynchronously; next burst (0x5000,2) issues as (0x5000,2).
- in_address=0xFFFF_FFFF_FFC0, burstcount=2 -> sub-bursts (0xFFFF_FFFF_FFC0,1),(0x0,1); address wraps cleanly.
